// File: rtl/sha256_wt_gen.sv
// SHA-256 message schedule for a 2-context interleaved round core.
// It emits one Wt/Kt pair per enabled cycle. Contexts alternate, ctx0 on even counts.
module sha256_wt_gen (
    input  logic        CLK,
    input  logic        rst,
    input  logic        glbl_en,
    input  logic        start,
    input  logic [31:0] din,
    output logic        din_rd,
    output logic [31:0] Wt,
    output logic [31:0] Kt,
    output logic [5:0]  round_o,
    output logic        ctx_o,
    output logic        wt_valid,
    output logic        busy,
    output logic        done
);

    localparam logic [31:0] K_ROM [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] sig0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    function automatic logic [31:0] sig1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'd0, x[31:10]};
    endfunction

    logic        busy_q,  busy_d;
    logic [6:0]  cnt_q,   cnt_d;
    logic [31:0] wt_q,    wt_d;
    logic [31:0] kt_q,    kt_d;
    logic [5:0]  round_q, round_d;
    logic        ctx_q,   ctx_d;
    logic        valid_q, valid_d;
    logic        done_q,  done_d;

    // Entry i holds the word produced i+1 cycles ago, with both contexts interleaved.
    // A word of the same context at schedule distance d therefore sits 2*d slots back.
    logic [31:0] win_q [32];
    logic [31:0] win_d [32];

    logic [5:0]  round;
    logic        ctx;
    logic [31:0] w_exp;
    logic [31:0] w_new;

    assign round  = cnt_q[6:1];
    assign ctx    = cnt_q[0];
    assign din_rd = busy_q & (cnt_q[6:5] == 2'b00);
    assign w_exp  = sig1(win_q[3]) + win_q[13] + sig0(win_q[29]) + win_q[31];
    assign w_new  = din_rd ? din : w_exp;

    // NOTE: every *_d gets its hold value first, so no path through this block
    // leaves a variable unassigned and no latch can be inferred.
    always_comb begin
        busy_d  = busy_q;
        cnt_d   = cnt_q;
        wt_d    = wt_q;
        kt_d    = kt_q;
        round_d = round_q;
        ctx_d   = ctx_q;
        valid_d = valid_q;
        done_d  = done_q;
        win_d   = win_q;

        if (glbl_en) begin
            if (busy_q) begin
                win_d[0] = w_new;
                for (int i = 1; i < 32; i++) begin
                    win_d[i] = win_q[i-1];
                end
                wt_d    = w_new;
                kt_d    = K_ROM[round];
                round_d = round;
                ctx_d   = ctx;
                valid_d = 1'b1;
                cnt_d   = cnt_q + 7'd1;
                done_d  = 1'b0;
                if (cnt_q == 7'd127) begin
                    // A start on the last edge chains the next block; cnt wraps to 0.
                    done_d = 1'b1;
                    busy_d = start;
                end
            end else begin
                valid_d = 1'b0;
                done_d  = 1'b0;
                if (start) begin
                    busy_d = 1'b1;
                    cnt_d  = 7'd0;
                end
            end
        end
    end

    // NOTE: state is updated with non-blocking assignments. All flops then sample
    // the values that were present before the edge, whatever order the statements run in.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            busy_q  <= 1'b0;
            cnt_q   <= 7'd0;
            wt_q    <= 32'd0;
            kt_q    <= 32'd0;
            round_q <= 6'd0;
            ctx_q   <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
            wt_q    <= wt_d;
            kt_q    <= kt_d;
            round_q <= round_d;
            ctx_q   <= ctx_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    // NOTE: the window has no reset. Each block loads 32 fresh words before any tap is read,
    // so this can map to plain shift-register resources.
    always_ff @(posedge CLK) begin
        win_q <= win_d;
    end

    assign Wt       = wt_q;
    assign Kt       = kt_q;
    assign round_o  = round_q;
    assign ctx_o    = ctx_q;
    assign wt_valid = valid_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_sha256_wt_gen.sv
// Directed bench for sha256_wt_gen. It covers the abc block, random stalls, back-to-back blocks,
// a mid-block reset and a start while busy, and compares against a reference schedule.
module tb_sha256_wt_gen;

    logic        CLK = 1'b0;
    logic        rst;
    logic        glbl_en;
    logic        start;
    logic [31:0] din;
    logic        din_rd;
    logic [31:0] Wt;
    logic [31:0] Kt;
    logic [5:0]  round_o;
    logic        ctx_o;
    logic        wt_valid;
    logic        busy;
    logic        done;

    sha256_wt_gen dut (
        .CLK      (CLK),
        .rst      (rst),
        .glbl_en  (glbl_en),
        .start    (start),
        .din      (din),
        .din_rd   (din_rd),
        .Wt       (Wt),
        .Kt       (Kt),
        .round_o  (round_o),
        .ctx_o    (ctx_o),
        .wt_valid (wt_valid),
        .busy     (busy),
        .done     (done)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [5:0]  round;
        logic        ctx;
        logic [31:0] wt;
    } word_t;

    typedef struct {
        logic [5:0]  round;
        logic        ctx;
        logic        chk_wt;
        logic [31:0] wt;
        logic [31:0] kt;
    } vec_t;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] din_q [$];
    word_t       exp_q [$];
    word_t       cap_q [$];
    logic [31:0] kt_cap [$];
    logic [31:0] msg [2][16];
    vec_t        vecs [12];
    bit          aborted;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] s0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] s1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    task automatic clear_model();
        din_q.delete();
        exp_q.delete();
    endtask

    // Expands msg with the textbook per-context recurrence. The input words and the
    // expected outputs are queued in interleaved order (ctx0 r, ctx1 r, ...).
    task automatic add_block();
        logic [31:0] w [2][64];
        word_t       wd;
        for (int c = 0; c < 2; c++) begin
            for (int t = 0; t < 16; t++) w[c][t] = msg[c][t];
            for (int t = 16; t < 64; t++)
                w[c][t] = s1(w[c][t-2]) + w[c][t-7] + s0(w[c][t-15]) + w[c][t-16];
        end
        for (int r = 0; r < 64; r++) begin
            for (int c = 0; c < 2; c++) begin
                if (r < 16) din_q.push_back(msg[c][r]);
                wd.round = 6'(r);
                wd.ctx   = 1'(c);
                wd.wt    = w[c][r];
                exp_q.push_back(wd);
            end
        end
    endtask

    task automatic set_abc();
        for (int t = 0; t < 16; t++) begin
            msg[0][t] = 32'h0;
            msg[1][t] = 32'h0;
        end
        msg[0][0]  = 32'h61626380;
        msg[0][15] = 32'h00000018;
    endtask

    task automatic set_alt();
        for (int t = 0; t < 16; t++) begin
            msg[0][t] = (32'h01010101 * 32'(t + 1)) ^ 32'hA5A50000;
            msg[1][t] = 32'h12345678 + 32'(t * 32'h0F0F1111);
        end
    endtask

    // Runs nblk blocks from idle. It can insert random stalls, assert start again at
    // busy-edge extra_start_at, or pulse rst before busy-edge rst_at.
    task automatic run(input int nblk, input bit stall, input int extra_start_at,
                       input int rst_at, output bit ab);
        int          e = 0, cons = 0, rises = 0, first_e = -1, invalid = 0, hold_err = 0;
        bit          started = 0, en, rd;
        logic        prev_done;
        logic [31:0] prev_wt;
        word_t       wd;
        ab = 0;
        cap_q.delete();
        kt_cap.delete();
        prev_wt   = Wt;
        prev_done = done;
        for (int cyc = 0; cyc < 3000 && e < 128 * nblk; cyc++) begin
            en      = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
            glbl_en = en;
            start   = !started || ((e % 128 == 127) && (e / 128 < nblk - 1)) || (e == extra_start_at);
            din     = (din_q.size() > 0) ? din_q[0] : 32'h0;
            rd      = din_rd;
            if (started && e == rst_at) begin
                #2 rst = 1'b1;
                #1;
                check("rst_mid_busy",   64'(busy),     64'd0);
                check("rst_mid_wt",     64'(Wt),       64'd0);
                check("rst_mid_kt",     64'(Kt),       64'd0);
                check("rst_mid_round",  64'(round_o),  64'd0);
                check("rst_mid_ctx",    64'(ctx_o),    64'd0);
                check("rst_mid_valid",  64'(wt_valid), 64'd0);
                check("rst_mid_din_rd", 64'(din_rd),   64'd0);
                @(posedge CLK);
                #1 rst = 1'b0;
                check("rst_mid_done",   64'(done),     64'd0);
                check("rst_no_done",    64'(rises),    64'd0);
                ab = 1;
                break;
            end
            @(posedge CLK);
            #1;
            if (en) begin
                if (!started) started = 1;
                else begin
                    e++;
                    if (rd) begin
                        cons++;
                        if (din_q.size() > 0) void'(din_q.pop_front());
                    end
                    if (wt_valid) begin
                        wd.round = round_o;
                        wd.ctx   = ctx_o;
                        wd.wt    = Wt;
                        cap_q.push_back(wd);
                        kt_cap.push_back(Kt);
                    end else invalid++;
                    if (done && !prev_done) begin
                        rises++;
                        if (first_e < 0) first_e = e;
                    end
                end
            end else if (Wt !== prev_wt || done !== prev_done) hold_err++;
            prev_wt   = Wt;
            prev_done = done;
        end
        if (ab) return;

        check("blk_edges",   64'(e),        64'(128 * nblk));
        check("done_rises",  64'(rises),    64'(nblk));
        check("done_first",  64'(first_e),  64'd128);
        check("din_consume", 64'(cons),     64'(32 * nblk));
        check("valid_gaps",  64'(invalid),  64'd0);
        check("stall_hold",  64'(hold_err), 64'd0);

        // The done pulse and the last word must persist across stalled cycles.
        glbl_en = 1'b0;
        start   = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge CLK);
            #1;
            check("done_held",  64'(done),     64'd1);
            check("valid_held", 64'(wt_valid), 64'd1);
        end
        glbl_en = 1'b1;
        @(posedge CLK);
        #1;
        check("idle_done",  64'(done),     64'd0);
        check("idle_valid", 64'(wt_valid), 64'd0);
        check("idle_busy",  64'(busy),     64'd0);
        check("idle_wt",    64'(Wt),       64'(exp_q[exp_q.size()-1].wt));

        check("cap_count", 64'(cap_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
            check($sformatf("w%0d_rc", i), 64'({cap_q[i].round, cap_q[i].ctx}),
                  64'({exp_q[i].round, exp_q[i].ctx}));
            check($sformatf("w%0d_wt", i), 64'(cap_q[i].wt), 64'(exp_q[i].wt));
        end
    endtask

    initial begin
        vecs[0]  = '{6'd0,  1'b0, 1'b1, 32'h61626380, 32'h428A2F98};
        vecs[1]  = '{6'd1,  1'b0, 1'b1, 32'h00000000, 32'h71374491};
        vecs[2]  = '{6'd15, 1'b0, 1'b1, 32'h00000018, 32'hC19BF174};
        vecs[3]  = '{6'd16, 1'b0, 1'b1, 32'h61626380, 32'hE49B69C1};
        vecs[4]  = '{6'd17, 1'b0, 1'b1, 32'h000F0000, 32'hEFBE4786};
        vecs[5]  = '{6'd18, 1'b0, 1'b1, 32'h7DA86405, 32'h0FC19DC6};
        vecs[6]  = '{6'd19, 1'b0, 1'b1, 32'h600003C6, 32'h240CA1CC};
        vecs[7]  = '{6'd0,  1'b1, 1'b1, 32'h00000000, 32'h428A2F98};
        vecs[8]  = '{6'd1,  1'b1, 1'b1, 32'h00000000, 32'h71374491};
        vecs[9]  = '{6'd40, 1'b1, 1'b1, 32'h00000000, 32'hA2BFE8A1};
        vecs[10] = '{6'd63, 1'b0, 1'b0, 32'h00000000, 32'hC67178F2};
        vecs[11] = '{6'd63, 1'b1, 1'b1, 32'h00000000, 32'hC67178F2};

        rst     = 1'b1;
        glbl_en = 1'b0;
        start   = 1'b0;
        din     = 32'h0;
        #1;
        check("reset_busy",   64'(busy),     64'd0);
        check("reset_wt",     64'(Wt),       64'd0);
        check("reset_kt",     64'(Kt),       64'd0);
        check("reset_round",  64'(round_o),  64'd0);
        check("reset_ctx",    64'(ctx_o),    64'd0);
        check("reset_valid",  64'(wt_valid), 64'd0);
        check("reset_done",   64'(done),     64'd0);
        check("reset_din_rd", 64'(din_rd),   64'd0);
        #11 rst = 1'b0;
        @(posedge CLK);
        #1;

        // abc block, unstalled, then the table of hand-computed words and constants.
        clear_model(); set_abc(); add_block();
        run(1, 1'b0, -1, -1, aborted);
        for (int i = 0; i < 12; i++) begin
            int idx;
            idx = int'(vecs[i].round) * 2 + int'(vecs[i].ctx);
            if (idx < cap_q.size()) begin
                if (vecs[i].chk_wt)
                    check($sformatf("vec%0d_wt", i), 64'(cap_q[idx].wt), 64'(vecs[i].wt));
                check($sformatf("vec%0d_kt", i), 64'(kt_cap[idx]), 64'(vecs[i].kt));
            end else check($sformatf("vec%0d_missing", i), 64'(cap_q.size()), 64'(idx + 1));
        end

        // abc block with random stalls.
        clear_model(); set_abc(); add_block();
        run(1, 1'b1, -1, -1, aborted);

        // Back-to-back: abc followed by a different message.
        clear_model(); set_abc(); add_block(); set_alt(); add_block();
        run(2, 1'b0, -1, -1, aborted);

        // Reset while round 40 is in flight, then a fresh abc block.
        clear_model(); set_abc(); add_block();
        run(1, 1'b0, -1, 81, aborted);
        check("rst_aborted", 64'(aborted), 64'd1);
        clear_model(); set_abc(); add_block();
        run(1, 1'b0, -1, -1, aborted);

        // A start at cnt=100 (round 50) is ignored.
        clear_model(); set_abc(); add_block();
        run(1, 1'b0, 100, -1, aborted);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
